// File: rtl/ro_puf_compare.sv
// Ring-oscillator PUF bit generator: counts synchronized rising edges of two
// oscillators over a fixed window and registers which one ran faster.
module ro_puf_compare #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_a,
  input  logic             osc_b,
  output logic             enable_a,
  output logic             enable_b,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] SETTLE_LAST =
    TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] WINDOW_LAST =
    TMR_W'((WINDOW_CYCLES > 0) ? WINDOW_CYCLES - 1 : 0);
  localparam logic SKIP_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         sync_a_q, sync_a_d;
  logic [2:0]         sync_b_q, sync_b_d;
  logic [CNT_W-1:0]   count_a_q, count_a_d;
  logic [CNT_W-1:0]   count_b_q, count_b_d;
  logic               response_q, response_d;
  logic               tie_q, tie_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               edge_a_c, edge_b_c;

  // [0],[1] synchronize; [2] is edge history, running in every state
  assign sync_a_d = {sync_a_q[1:0], osc_a};
  assign sync_b_d = {sync_b_q[1:0], osc_b};
  assign edge_a_c = sync_a_q[1] & ~sync_a_q[2];
  assign edge_b_c = sync_b_q[1] & ~sync_b_q[2];

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    response_d = response_q;
    tie_d      = tie_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tmr_d      = '0;
          count_a_d  = '0;
          count_b_d  = '0;
          response_d = 1'b0;
          tie_d      = 1'b0;
          state_d    = SKIP_SETTLE ? ST_MEASURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (edge_a_c && (count_a_q != CNT_MAX)) count_a_d = count_a_q + CNT_W'(1);
        if (edge_b_c && (count_b_q != CNT_MAX)) count_b_d = count_b_q + CNT_W'(1);
        if (tmr_q == WINDOW_LAST) begin
          tmr_d   = '0;
          state_d = ST_COMPARE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_COMPARE: begin
        response_d = (count_a_q > count_b_q);
        tie_d      = (count_a_q == count_b_q);
        state_d    = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // status outputs are registered from the next state so they align with it
    enable_d = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    busy_d   = (state_d == ST_SETTLE) || (state_d == ST_MEASURE) ||
               (state_d == ST_COMPARE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      count_a_q  <= '0;
      count_b_q  <= '0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      enable_q   <= enable_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign enable_a = enable_q;
  assign enable_b = enable_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign response = response_q;
  assign tie      = tie_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_puf_compare.sv
// Directed bench for ro_puf_compare: clock-derived oscillator models, a vector
// table of frequency pairs, and hand sequences for reset/re-trigger/saturation.
module tb_ro_puf_compare;

  localparam int unsigned W  = 100;
  localparam int unsigned S  = 4;
  localparam int unsigned LAT1 = S + W + 2;
  localparam int unsigned LAT2 = 0 + W + 2;

  logic clk, rst, start, start2, osc_a, osc_b;
  logic enable_a, enable_b, busy, done, response, tie;
  logic [15:0] count_a, count_b;
  logic enable_a2, enable_b2, busy2, done2, response2, tie2;
  logic [3:0] count_a2, count_b2;

  int checks = 0;
  int errors = 0;

  int per_a = 0, per_b = 0, ph_a = 0, ph_b = 0;
  bit ab_same = 0;

  ro_puf_compare #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .osc_a(osc_a), .osc_b(osc_b),
    .enable_a(enable_a), .enable_b(enable_b), .busy(busy), .done(done),
    .response(response), .tie(tie), .count_a(count_a), .count_b(count_b));

  ro_puf_compare #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(0), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .osc_a(osc_a), .osc_b(osc_b),
    .enable_a(enable_a2), .enable_b(enable_b2), .busy(busy2), .done(done2),
    .response(response2), .tie(tie2), .count_a(count_a2), .count_b(count_b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oscillator models: period in clk cycles, high for floor(p/2); 0 = stuck low
  always @(negedge clk) begin
    if (per_a == 0) osc_a = 1'b0;
    else begin ph_a = (ph_a + 1) % per_a; osc_a = (ph_a < per_a / 2); end
    if (ab_same) osc_b = osc_a;
    else if (per_b == 0) osc_b = 1'b0;
    else begin ph_b = (ph_b + 1) % per_b; osc_b = (ph_b < per_b / 2); end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // pulse start; returns number of clk edges until done is seen (0 = timeout)
  task automatic run_meas(input bit sel, output int lat);
    lat = 0;
    @(negedge clk);
    if (sel) start2 = 1'b1; else start = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b0; start2 = 1'b0; end
      if ((sel ? done2 : done) === 1'b1) begin lat = i; break; end
    end
  endtask

  typedef struct {
    string name;
    int    pa;
    int    pb;
    bit    same;
    bit    exp_resp;
    bit    exp_tie;
    int    a_lo, a_hi, b_lo, b_hi;
  } vec_t;

  vec_t vecs[6];
  int lat, pulses, first_at, second_at;

  initial begin
    vecs[0] = '{"a4_b5",  4, 5, 1'b0, 1'b1, 1'b0, 24, 26, 19, 21};
    vecs[1] = '{"a6_b3",  6, 3, 1'b0, 1'b0, 1'b0, 15, 18, 32, 35};
    vecs[2] = '{"same4",  4, 4, 1'b1, 1'b0, 1'b1, 24, 26, 24, 26};
    vecs[3] = '{"a5_b4",  5, 4, 1'b0, 1'b0, 1'b0, 19, 21, 24, 26};
    vecs[4] = '{"static", 0, 0, 1'b0, 1'b0, 1'b1,  0,  0,  0,  0};
    vecs[5] = '{"a3_b0",  3, 0, 1'b0, 1'b1, 1'b0, 32, 35,  0,  0};

    start = 1'b0; start2 = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    // asynchronous reset: checked before the first clock edge
    chk("rst_enable_a", enable_a, 0);
    chk("rst_enable_b", enable_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_tie", tie, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_count_b", count_b, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      per_a = vecs[v].pa; per_b = vecs[v].pb; ab_same = vecs[v].same;
      repeat (3) @(negedge clk);
      run_meas(1'b0, lat);
      chk({vecs[v].name, "_latency"}, lat, LAT1);
      chk({vecs[v].name, "_response"}, response, vecs[v].exp_resp);
      chk({vecs[v].name, "_tie"}, tie, vecs[v].exp_tie);
      chk_rng({vecs[v].name, "_count_a"}, count_a, vecs[v].a_lo, vecs[v].a_hi);
      chk_rng({vecs[v].name, "_count_b"}, count_b, vecs[v].b_lo, vecs[v].b_hi);
      if (vecs[v].name == "a6_b3")
        chk_rng("a6_b3_ratio", longint'(count_b) - 2 * longint'(count_a), -2, 2);
      repeat (3) @(negedge clk);
      chk({vecs[v].name, "_hold_done"}, done, 0);
      chk({vecs[v].name, "_hold_busy"}, busy, 0);
      chk({vecs[v].name, "_hold_response"}, response, vecs[v].exp_resp);
      chk({vecs[v].name, "_hold_tie"}, tie, vecs[v].exp_tie);
      chk_rng({vecs[v].name, "_hold_count_a"}, count_a, vecs[v].a_lo, vecs[v].a_hi);
    end

    // reset in the middle of MEASURE
    per_a = 4; per_b = 5; ab_same = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_enable_before", enable_a, 1);
    chk("mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_enable_a", enable_a, 0);
    chk("mid_rst_enable_b", enable_b, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    run_meas(1'b0, lat);
    chk("post_rst_latency", lat, LAT1);
    chk("post_rst_response", response, 1);
    chk_rng("post_rst_count_a", count_a, 24, 26);

    // start pulses while busy are ignored
    @(negedge clk); start = 1'b1;
    lat = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = (i == 20 || i == 60 || i == 105);
      if (done === 1'b1) begin lat = i; break; end
    end
    start = 1'b0;
    chk("busy_start_latency", lat, LAT1);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("busy_start_no_extra_done", pulses, 0);

    // start held high: back-to-back runs, one IDLE cycle between them
    pulses = 0; first_at = 0; second_at = 0;
    @(negedge clk); start = 1'b1;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) begin second_at = i; start = 1'b0; end
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 2);
    chk("held_first_latency", first_at, LAT1);
    chk("held_gap", second_at - first_at, S + W + 3);

    // 4-bit counters, no settle phase: A saturates at 15
    per_a = 2; per_b = 0; ab_same = 1'b0;
    repeat (3) @(negedge clk);
    run_meas(1'b1, lat);
    chk("sat_latency", lat, LAT2);
    chk("sat_count_a", count_a2, 15);
    chk("sat_count_b", count_b2, 0);
    chk("sat_response", response2, 1);
    chk("sat_tie", tie2, 0);
    chk("sat_enable_off", enable_a2 | enable_b2 | busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_compare.md
RO_PUF_COMPARE -- requirements
Module: ro_puf_compare

Interface
REQ-001 Parameter: WINDOW_CYCLES, default 1024, number of clk cycles in the edge-counting window (legal range 1..65535).
REQ-002 Parameter: SETTLE_CYCLES, default 16, number of clk cycles the oscillators run before counting starts (legal range 0..255).
REQ-003 Parameter: CNT_W, default 16, width of each edge counter.
REQ-004 Port: clk, input, 1, the single system clock.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: start, input, 1, request for one measurement; sampled in IDLE only.
REQ-007 Port: osc_a, input, 1, output_signal of ring oscillator A (asynchronous to clk).
REQ-008 Port: osc_b, input, 1, output_signal of ring oscillator B (asynchronous to clk).
REQ-009 Port: enable_a, output, 1, drives the enable of oscillator A.
REQ-010 Port: enable_b, output, 1, drives the enable of oscillator B.
REQ-011 Port: busy, output, 1, high from the cycle after start is accepted until done.
REQ-012 Port: done, output, 1, one-cycle pulse when a result is valid.
REQ-013 Port: response, output, 1, PUF bit: 1 when count_a > count_b.
REQ-014 Port: tie, output, 1, high when count_a == count_b.
REQ-015 Port: count_a, output, CNT_W, final edge count for A.
REQ-016 Port: count_b, output, CNT_W, final edge count for B.

Function
REQ-017 The block SHALL implement the states IDLE, SETTLE, MEASURE, COMPARE and DONE.
REQ-018 IDLE->SETTLE SHALL occur on a clk edge with start=1; the block SHALL go straight to MEASURE if SETTLE_CYCLES=0.
REQ-019 SETTLE->MEASURE SHALL occur after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-020 MEASURE->COMPARE SHALL occur after exactly WINDOW_CYCLES cycles in MEASURE.
REQ-021 COMPARE->DONE SHALL occur after 1 cycle, and DONE->IDLE SHALL occur after 1 cycle.
REQ-022 enable_a and enable_b SHALL both be 1 in SETTLE and MEASURE, and 0 in all other states.
REQ-023 osc_a and osc_b SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector (third flop).
REQ-024 A counter SHALL increment by 1 per detected rising edge, only while in MEASURE.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Counters SHALL clear to 0 on entry to SETTLE.
REQ-027 Edge-detector history SHALL be maintained continuously, so an edge straddling the SETTLE->MEASURE boundary is counted at most once.
REQ-028 Counting is valid only when oscillator frequency < clk/2; the block SHALL NOT attempt to detect aliasing.
REQ-029 In COMPARE the block SHALL register response=(count_a>count_b) and tie=(count_a==count_b), both unsigned.
REQ-030 On a tie, response SHALL be 0 and tie SHALL be 1.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 count_a, count_b, response and tie SHALL hold their values from DONE until the next entry to SETTLE.
REQ-033 busy SHALL be 1 in SETTLE, MEASURE and COMPARE, and 0 in IDLE and DONE.
REQ-034 start SHALL be ignored outside IDLE; start held high SHALL re-trigger on the cycle after DONE.
REQ-035 Latency from start accepted to done SHALL be exactly SETTLE_CYCLES + WINDOW_CYCLES + 2 clk cycles.

Reset
REQ-036 While rst=1, state SHALL be IDLE and all outputs SHALL be 0 (enable_a, enable_b, busy, done, response, tie, count_a, count_b), without waiting for clk.
REQ-037 rst asserted during SETTLE or MEASURE SHALL drop enable_a and enable_b asynchronously, and no done SHALL follow.
REQ-038 Synchronizer and edge-detector flops SHALL reset to 0.

Verification
REQ-039 Scenario: WINDOW_CYCLES=100, SETTLE_CYCLES=4, osc_a period 4 clk, osc_b period 5 clk, pulse start -> done 106 cycles later; count_a=25±1, count_b=20±1, response=1, tie=0.
REQ-040 Scenario: osc_a period 6 clk, osc_b period 3 clk -> response=0, tie=0, count_b ≈ 2×count_a.
REQ-041 Scenario: osc_a and osc_b driven identically (period 4) -> count_a==count_b, tie=1, response=0.
REQ-042 Scenario: CNT_W=4, osc_a period 2, WINDOW_CYCLES=100 -> count_a=15 (saturated), no wrap.
REQ-043 Scenario: rst pulsed mid-MEASURE -> enable_a=enable_b=0 immediately, busy=0, no done pulse; a following start runs a clean full measurement.
REQ-044 Scenario: start held high through two runs -> exactly two done pulses 1 idle cycle apart; start pulses during busy have no effect.
